// File: rtl/reg_pipe_hs.sv
// reg_pipe_hs: DEPTH-stage WIDTH-bit pipeline register with a valid bit per stage
// and valid/ready handshakes at both ends. Bubbles collapse and a full pipeline
// keeps streaming at one word per cycle, because ready passes straight through
// from the output to the input. All state changes on the falling edge of CLK.
// CLR empties the pipeline synchronously and leaves the data registers as they are.
module reg_pipe_hs #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         CLR,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic [WIDTH-1:0]             D,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [WIDTH-1:0]             Q,
    output logic [$clog2(DEPTH+1)-1:0]   COUNT
);

    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] take;
    logic             in_fire;
    logic             out_fire;

    // Advance chain: a stage moves on when its word can leave, either because
    // the next stage is empty or because that stage is itself moving on.
    // The chain resolves from the output stage back toward the input.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and give every output a
        // default first, so later statements see updated values and no latch is inferred.
        adv          = '0;
        adv[DEPTH-1] = valid_q[DEPTH-1] & OUT_READY;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            adv[k] = valid_q[k] & (~valid_q[k+1] | adv[k+1]);
        end
        // A flush freezes every transfer, including moves between stages.
        if (CLR) begin
            adv = '0;
        end
    end

    assign IN_READY  = ~CLR & (~valid_q[0] | adv[0]);
    assign OUT_VALID = valid_q[DEPTH-1] & ~CLR;
    assign Q         = data_q[DEPTH-1];
    assign COUNT     = count_q;

    assign in_fire  = IN_VALID & IN_READY;
    assign out_fire = adv[DEPTH-1];

    // Load strobes: stage 0 takes the input word, each later stage takes the
    // word that its predecessor is advancing.
    always_comb begin
        take    = '0;
        take[0] = in_fire;
        for (int k = 1; k < DEPTH; k++) begin
            take[k] = adv[k-1];
        end
    end

    // Next state: shift the words, update the valid bits, and track the
    // occupancy from the two end transfers.
    always_comb begin
        data_d  = data_q;
        valid_d = take | (valid_q & ~adv);
        count_d = count_q;

        if (take[0]) begin
            data_d[0] = D;
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (take[k]) begin
                data_d[k] = data_q[k-1];
            end
        end

        unique case ({in_fire, out_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (CLR) begin
            valid_d = '0;
            count_d = '0;
        end
    end

    // State registers, updated on the falling edge with an asynchronous reset.
    always_ff @(negedge CLK or posedge RST) begin
        // NOTE: the data array is reset too, because Q has to read zero straight
        // out of reset and not only once a word has reached the last stage.
        if (RST) begin
            data_q  <= '{default: '0};
            valid_q <= '0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_reg_pipe_hs.sv
// tb_reg_pipe_hs: table-driven and hand-written sequences on a DEPTH=3 instance,
// plus randomized traffic on DEPTH=3 and DEPTH=1 instances checked against a
// FIFO-with-arrival-time reference model.
module tb_reg_pipe_hs;

    logic       CLK = 1'b0;
    logic       RST;

    logic       clr3, iv3, or3, ir3, ov3;
    logic [7:0] d3, q3;
    logic [1:0] cnt3;

    logic       clr1, iv1, or1, ir1, ov1;
    logic [7:0] d1, q1;
    logic [0:0] cnt1;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    reg_pipe_hs #(.WIDTH(8), .DEPTH(3)) dut3 (
        .CLK(CLK), .RST(RST), .CLR(clr3),
        .IN_VALID(iv3), .IN_READY(ir3), .D(d3),
        .OUT_VALID(ov3), .OUT_READY(or3), .Q(q3), .COUNT(cnt3)
    );

    reg_pipe_hs #(.WIDTH(8), .DEPTH(1)) dut1 (
        .CLK(CLK), .RST(RST), .CLR(clr1),
        .IN_VALID(iv1), .IN_READY(ir1), .D(d1),
        .OUT_VALID(ov1), .OUT_READY(or1), .Q(q1), .COUNT(cnt1)
    );

    // Active edge is the falling edge; stimulus and sampling use the rising edge.
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Each instance is a FIFO of (word, accept edge). The head word becomes
    // visible on Q at edge max(accept + DEPTH - 1, edge its predecessor left).
    logic [7:0] mw [2][$];
    int         ma [2][$];
    int         hav [2];
    logic [7:0] qm [2];
    int         n_edge = 0;
    bit         mon_en = 1'b0;

    function automatic int dep(input int i);
        return (i == 0) ? 3 : 1;
    endfunction

    function automatic logic exp_ov(input int i, input logic clr);
        return !clr && (mw[i].size() > 0) && (hav[i] < n_edge);
    endfunction

    function automatic logic exp_ir(input int i, input logic clr, input logic ordy);
        return !clr && ((mw[i].size() < dep(i)) || (exp_ov(i, clr) && ordy));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mw[i].delete();
            ma[i].delete();
            hav[i] = 0;
            qm[i]  = 8'h00;
        end
    endtask

    task automatic model_edge(input int i, input logic clr, input logic iv,
                              input logic [7:0] d, input logic ordy);
        logic ov;
        logic ir;
        bit   head_new;
        int   t;
        ov       = exp_ov(i, clr);
        ir       = exp_ir(i, clr, ordy);
        head_new = 1'b0;
        if (clr) begin
            mw[i].delete();
            ma[i].delete();
        end else begin
            if (ov && ordy) begin
                void'(mw[i].pop_front());
                void'(ma[i].pop_front());
                head_new = 1'b1;
            end
            if (iv && ir) begin
                if (mw[i].size() == 0) head_new = 1'b1;
                mw[i].push_back(d);
                ma[i].push_back(n_edge);
            end
            if (head_new && mw[i].size() > 0) begin
                t      = ma[i][0] + dep(i) - 1;
                hav[i] = (t > n_edge) ? t : n_edge;
            end
            if (mw[i].size() > 0 && hav[i] == n_edge) qm[i] = mw[i][0];
        end
    endtask

    // Advance the model at every active edge outside reset.
    always @(negedge CLK) begin
        if (!RST) begin
            model_edge(0, clr3, iv3, d3, or3);
            model_edge(1, clr1, iv1, d1, or1);
            n_edge++;
        end
    end

    // Compare both instances against the model once per cycle, before the edge.
    always @(posedge CLK) begin
        #1;
        if (mon_en && !RST) begin
            check("m3_in_ready",  {31'd0, ir3}, {31'd0, exp_ir(0, clr3, or3)});
            check("m3_out_valid", {31'd0, ov3}, {31'd0, exp_ov(0, clr3)});
            check("m3_q",         {24'd0, q3},  {24'd0, qm[0]});
            check("m3_count",     {30'd0, cnt3}, 32'(mw[0].size()));
            check("m1_in_ready",  {31'd0, ir1}, {31'd0, exp_ir(1, clr1, or1)});
            check("m1_out_valid", {31'd0, ov1}, {31'd0, exp_ov(1, clr1)});
            check("m1_q",         {24'd0, q1},  {24'd0, qm[1]});
            check("m1_count",     {31'd0, cnt1}, 32'(mw[1].size()));
        end
    end

    // ---------------- directed stimulus ----------------
    typedef struct {
        logic       clr;
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       ir;
        logic       ov;
        logic [7:0] q;
        logic [1:0] cnt;
    } vec_t;

    vec_t tbl [19];

    task automatic set3(input logic c, input logic v, input logic [7:0] d, input logic r);
        @(posedge CLK);
        clr3 = c; iv3 = v; d3 = d; or3 = r;
    endtask

    task automatic set1(input logic c, input logic v, input logic [7:0] d, input logic r);
        @(posedge CLK);
        clr1 = c; iv1 = v; d1 = d; or1 = r;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Columns: clr, in_valid, d, out_ready | in_ready, out_valid, q, count (before the edge)
        tbl[0]  = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
        tbl[1]  = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 8'h00, 2'd1};
        tbl[2]  = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 8'h00, 2'd2};
        tbl[3]  = '{1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 8'h11, 2'd3};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 2'd3};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 2'd2};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44, 2'd1};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h44, 2'd0};
        tbl[8]  = '{1'b0, 1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 8'h44, 2'd0};
        tbl[9]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h44, 2'd1};
        tbl[10] = '{1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b0, 8'h44, 2'd2};
        tbl[11] = '{1'b0, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 8'hA0, 2'd3};
        tbl[12] = '{1'b0, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 8'hA0, 2'd3};
        tbl[13] = '{1'b0, 1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 8'hA0, 2'd3};
        tbl[14] = '{1'b0, 1'b1, 8'hA4, 1'b1, 1'b1, 1'b1, 8'hA1, 2'd3};
        tbl[15] = '{1'b0, 1'b1, 8'hB0, 1'b1, 1'b1, 1'b1, 8'hA2, 2'd3};
        tbl[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA3, 2'd3};
        tbl[17] = '{1'b1, 1'b1, 8'hC0, 1'b1, 1'b0, 1'b0, 8'hA4, 2'd2};
        tbl[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA4, 2'd0};

        RST  = 1'b1;
        clr3 = 1'b0; iv3 = 1'b0; d3 = 8'h00; or3 = 1'b0;
        clr1 = 1'b0; iv1 = 1'b0; d1 = 8'h00; or1 = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge CLK);
        #2;
        check("rst_q3",   {24'd0, q3},   32'h0);
        check("rst_ov3",  {31'd0, ov3},  32'h0);
        check("rst_cnt3", {30'd0, cnt3}, 32'h0);
        check("rst_q1",   {24'd0, q1},   32'h0);
        check("rst_ov1",  {31'd0, ov1},  32'h0);
        check("rst_cnt1", {31'd0, cnt1}, 32'h0);
        RST    = 1'b0;
        mon_en = 1'b1;

        // Streaming, back-pressure, full pass-through and flush
        for (int i = 0; i < 19; i++) begin
            set3(tbl[i].clr, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            #2;
            check($sformatf("vec%0d_in_ready", i),  {31'd0, ir3},  {31'd0, tbl[i].ir});
            check($sformatf("vec%0d_out_valid", i), {31'd0, ov3},  {31'd0, tbl[i].ov});
            check($sformatf("vec%0d_q", i),         {24'd0, q3},   {24'd0, tbl[i].q});
            check($sformatf("vec%0d_count", i),     {30'd0, cnt3}, {30'd0, tbl[i].cnt});
        end

        // Asynchronous reset between edges while two words are held
        set3(1'b0, 1'b1, 8'h71, 1'b0);
        set3(1'b0, 1'b1, 8'h72, 1'b0);
        set3(1'b0, 1'b0, 8'h00, 1'b0);
        #2;
        check("pre_rst_count", {30'd0, cnt3}, 32'd2);
        RST = 1'b1;
        model_reset();
        #1;
        check("mid_rst_q",     {24'd0, q3},   32'h0);
        check("mid_rst_ov",    {31'd0, ov3},  32'h0);
        check("mid_rst_count", {30'd0, cnt3}, 32'h0);
        #1;
        RST = 1'b0;
        set3(1'b0, 1'b1, 8'h5A, 1'b1);
        #2;
        check("post_rst_accept", {31'd0, ir3}, 32'h1);
        set3(1'b0, 1'b0, 8'h00, 1'b1);
        #2;
        check("lat_edge1_ov", {31'd0, ov3}, 32'h0);
        set3(1'b0, 1'b0, 8'h00, 1'b1);
        #2;
        check("lat_edge2_ov", {31'd0, ov3}, 32'h0);
        set3(1'b0, 1'b0, 8'h00, 1'b1);
        #2;
        check("lat_edge3_ov", {31'd0, ov3}, 32'h1);
        check("lat_edge3_q",  {24'd0, q3},  32'h5A);
        set3(1'b0, 1'b0, 8'h00, 1'b0);

        // DEPTH=1: stall then full-throughput pass-through ready
        set1(1'b0, 1'b1, 8'hE1, 1'b0);
        #2;
        check("d1_first_ready", {31'd0, ir1}, 32'h1);
        set1(1'b0, 1'b1, 8'hE2, 1'b0);
        #2;
        check("d1_full_ready", {31'd0, ir1},  32'h0);
        check("d1_full_q",     {24'd0, q1},   32'hE1);
        check("d1_full_count", {31'd0, cnt1}, 32'h1);
        set1(1'b0, 1'b1, 8'hE2, 1'b1);
        #2;
        check("d1_pass_ready", {31'd0, ir1}, 32'h1);
        set1(1'b0, 1'b0, 8'h00, 1'b1);
        #2;
        check("d1_next_q",     {24'd0, q1},   32'hE2);
        check("d1_next_count", {31'd0, cnt1}, 32'h1);
        set1(1'b0, 1'b0, 8'h00, 1'b0);
        #2;
        check("d1_empty_ov", {31'd0, ov1}, 32'h0);

        // Randomized traffic on both instances, checked by the model every cycle
        for (int i = 0; i < 800; i++) begin
            @(posedge CLK);
            clr3 = ($urandom_range(0, 19) == 0);
            iv3  = 1'($urandom_range(0, 1));
            d3   = 8'($urandom);
            or3  = ($urandom_range(0, 3) != 0);
            clr1 = ($urandom_range(0, 39) == 0);
            d1   = 8'($urandom);
            if (i < 200) begin
                iv1 = ((i % 2) == 0) && ($urandom_range(0, 3) != 0);
                or1 = ((i % 2) == 1) && ($urandom_range(0, 3) != 0);
            end else begin
                iv1 = 1'($urandom_range(0, 1));
                or1 = 1'($urandom_range(0, 1));
            end
        end

        @(posedge CLK);
        clr3 = 1'b0; iv3 = 1'b0; or3 = 1'b1;
        clr1 = 1'b0; iv1 = 1'b0; or1 = 1'b1;
        repeat (6) @(posedge CLK);
        #2;
        check("drain_count3", {30'd0, cnt3}, 32'h0);
        check("drain_count1", {31'd0, cnt1}, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
